// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// The per-channel falling-edge pulse is built only when DEBOUNCE_RELEASE_PULSE_EN is defined.
package debounce_pkg;

  localparam int DEFAULT_NCH        = 4;
  localparam int MAX_NCH            = 32;
  localparam int DEFAULT_STABLE_CNT = 10;
  localparam int MIN_STABLE_CNT     = 2;
  localparam int MAX_STABLE_CNT     = 255;

  // Bits needed to hold 0..stable_cnt.
  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, agreement counter, level and edge pulses.
// Falling-edge pulse output exists only when DEBOUNCE_RELEASE_PULSE_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic fall
`endif
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (tick) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          // This sample completes the agreeing run: accept the new level now.
          level <= ~level;
          cnt   <= '0;
          press <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fall <= 1'b0;
    end else begin
      fall <= tick && (sync[1] != level) && (cnt == LAST) && level;
    end
  end
`endif

endmodule

// File: rtl/multi_debounce.sv
// NCH independent debounce channels sharing one clock, reset and sample strobe.
// D_release exists only when DEBOUNCE_RELEASE_PULSE_EN is defined.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int NCH        = DEFAULT_NCH,
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [NCH-1:0] D_in,
  output logic [NCH-1:0] D_level,
  output logic [NCH-1:0] D_press
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic [NCH-1:0] D_release
`endif
);

  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("multi_debounce: NCH=%0d outside 1..%0d", NCH, MAX_NCH);
  end

  if (STABLE_CNT < MIN_STABLE_CNT || STABLE_CNT > MAX_STABLE_CNT) begin : g_bad_cnt
    $error("multi_debounce: STABLE_CNT=%0d outside %0d..%0d",
           STABLE_CNT, MIN_STABLE_CNT, MAX_STABLE_CNT);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT(STABLE_CNT)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (D_in[i]),
      .level(D_level[i]),
      .press(D_press[i])
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      ,
      .fall (D_release[i])
`endif
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: vector table with expected-value queue,
// plus hand sequences for reset corner cases and a slow-tick instance.
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] d_in;
  logic [3:0] d_level;
  logic [3:0] d_press;
  logic [3:0] d_release;

  logic       tick3 = 1'b0;
  logic [1:0] ph3 = 2'd0;
  logic [0:0] d3_in;
  logic [0:0] d3_level;
  logic [0:0] d3_press;
  logic [0:0] d3_release;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Slow strobe for the second instance: one clk wide, every 4th clk.
  always @(negedge clk) begin
    ph3   = ph3 + 2'd1;
    tick3 = (ph3 == 2'd0);
  end

  multi_debounce #(.NCH(4), .STABLE_CNT(10)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .D_in     (d_in),
    .D_level  (d_level),
    .D_press  (d_press)
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    ,
    .D_release(d_release)
`endif
  );

  multi_debounce #(.NCH(1), .STABLE_CNT(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick3),
    .D_in     (d3_in),
    .D_level  (d3_level),
    .D_press  (d3_press)
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    ,
    .D_release(d3_release)
`endif
  );

`ifndef DEBOUNCE_RELEASE_PULSE_EN
  assign d_release  = '0;
  assign d3_release = '0;
`endif

  typedef struct {
    string      name;
    logic [3:0] din;
    int         ncyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] din, input int ncyc,
                     input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    vec_t v;
    v.name = nm; v.din = din; v.ncyc = ncyc; v.lvl = lvl; v.prs = prs; v.rel = rel;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    int   k;
    int   seen;
    int   pulses;
    logic t;

    // Each vector: drive din just after an edge, wait ncyc edges, then sample.
    add("idle",         4'b0000, 12, 4'b0000, 4'b0000, 4'b0000);
    add("step0_pre",    4'b0001, 11, 4'b0000, 4'b0000, 4'b0000);
    add("step0_acc",    4'b0001,  1, 4'b0001, 4'b0001, 4'b0000);
    add("step0_end",    4'b0001,  1, 4'b0001, 4'b0000, 4'b0000);
    add("fall0_acc",    4'b0000, 12, 4'b0000, 4'b0000, 4'b0001);
    add("fall0_end",    4'b0000,  1, 4'b0000, 4'b0000, 4'b0000);
    add("dual_rise",    4'b1001, 12, 4'b1001, 4'b1001, 4'b0000);
    add("dual_rise_end",4'b1001,  1, 4'b1001, 4'b0000, 4'b0000);
    add("dual_fall",    4'b0000, 12, 4'b0000, 4'b0000, 4'b1001);
    add("dual_fall_end",4'b0000,  1, 4'b0000, 4'b0000, 4'b0000);
    add("glitch_run9",  4'b0010,  9, 4'b0000, 4'b0000, 4'b0000);
    add("glitch_gap",   4'b0000,  1, 4'b0000, 4'b0000, 4'b0000);
    add("glitch_pre",   4'b0010, 11, 4'b0000, 4'b0000, 4'b0000);
    add("glitch_acc",   4'b0010,  1, 4'b0010, 4'b0010, 4'b0000);
    add("glitch_end",   4'b0010,  1, 4'b0010, 4'b0000, 4'b0000);
    add("ch1_fall",     4'b0000, 12, 4'b0000, 4'b0000, 4'b0010);
    add("ch1_fall_end", 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000);

    reset = 1'b1;
    tick  = 1'b1;
    d_in  = 4'b0000;
    d3_in = 1'b0;
    #1;
    chk("reset_level", d_level, 4'b0000);
    chk("reset_press", d_press, 4'b0000);
    chk("reset_release", d_release, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      d_in   = vecs[i].din;
      e.name = vecs[i].name; e.lvl = vecs[i].lvl; e.prs = vecs[i].prs; e.rel = vecs[i].rel;
      exp_q.push_back(e);
      repeat (vecs[i].ncyc) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({e.name, "_level"}, d_level, e.lvl);
      chk({e.name, "_press"}, d_press, e.prs);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      chk({e.name, "_release"}, d_release, e.rel);
`endif
    end

    // Reset mid-count: ch3 already accepted high, ch0 counter part-way.
    d_in = 4'b1000;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_rst_level", d_level, 4'b1000);
    d_in = 4'b1001;
    repeat (9) @(posedge clk);
    #2;
    chk("midcount_level", d_level, 4'b1000);
    reset = 1'b1;
    #1;
    chk("async_rst_level", d_level, 4'b0000);
    chk("async_rst_press", d_press, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("post_rst_pre_level", d_level, 4'b0000);
    chk("post_rst_pre_press", d_press, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst_acc_level", d_level, 4'b1001);
    chk("post_rst_acc_press", d_press, 4'b1001);

    // Reset while the press pulse is high truncates it; nothing re-emitted.
    #2;
    reset = 1'b1;
    #1;
    chk("trunc_press", d_press, 4'b0000);
    d_in = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (d_press != 4'b0000) pulses++;
    end
    chk("no_reemit_pulses", pulses, 0);
    chk("no_reemit_level", d_level, 4'b0000);

    // Slow-tick instance: level flips on the 3rd strobe that sees the synced input.
    @(posedge clk);
    #1;
    d3_in = 1'b1;
    k = 0;
    seen = 0;
    while (seen < 3 && k < 40) begin
      @(posedge clk);
      t = tick3;
      #1;
      k++;
      if (k >= 3 && t) seen++;
      if (seen < 3) begin
        chk("slow_hold_level", d3_level, 1'b0);
      end else begin
        chk("slow_acc_level", d3_level, 1'b1);
        chk("slow_acc_press", d3_press, 1'b1);
      end
    end
    chk("slow_budget", (k < 40), 1'b1);
    @(posedge clk);
    #1;
    chk("slow_press_width", d3_press, 1'b0);
    chk("slow_level_hold", d3_level, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent input channels, legal range 1..32.
REQ-002 SHALL have parameter STABLE_CNT, default 10: consecutive agreeing samples required to accept a new level, legal range 2..255.
REQ-003 SHALL reject out-of-range NCH or STABLE_CNT as an elaboration error.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  sample enable (e.g. 500 Hz strobe, one clk wide); tie high to sample every clk.
REQ-007 D_in  input  NCH  raw, asynchronous, bouncing inputs (buttons/switches).
REQ-008 D_level  output  NCH  debounced, registered level per channel.
REQ-009 D_press  output  NCH  one-clk pulse per channel on accepted 0->1 transition.
REQ-010 D_release  output  NCH  one-clk pulse per channel on accepted 1->0 transition (present only under REQ-026).

Function
REQ-011 Each D_in bit SHALL pass through a 2-flop synchronizer clocked every clk, independent of tick.
REQ-012 Each channel SHALL hold a sample counter of width ceil(log2(STABLE_CNT+1)) bits.
REQ-013 On a clk edge with tick=1: synchronized bit != D_level -> counter increments; synchronized bit == D_level -> counter clears to 0.
REQ-014 On a clk edge with tick=0: counter, D_level unchanged; no pulse generated.
REQ-015 When an increment would make the counter equal STABLE_CNT, SHALL on that same edge invert D_level, clear counter, and assert the matching pulse.
REQ-016 D_press/D_release SHALL be high for exactly one clk cycle after the accepting edge, then low, regardless of tick.
REQ-017 With tick tied high, a clean input step SHALL reach D_level exactly 2+STABLE_CNT clk edges after the edge that first captures it.
REQ-018 Any disagreeing run shorter than STABLE_CNT samples SHALL be discarded (counter cleared), producing no level change and no pulse.
REQ-019 Counter SHALL never wrap; it never exceeds STABLE_CNT-1 at rest.
REQ-020 Channels SHALL be fully independent; simultaneous acceptances on several channels SHALL pulse together in the same cycle.
REQ-021 D_press and D_release of one channel SHALL never be high in the same cycle.

Reset
REQ-022 reset=1 SHALL immediately clear synchronizers, counters, D_level, D_press, D_release to 0, including mid-count.
REQ-023 After reset deasserts, an input already held high SHALL be treated as a new press: D_press fires once after REQ-017 latency.
REQ-024 A pulse in flight when reset asserts SHALL be truncated; no pulse re-emitted after reset.
REQ-025 reset SHALL be applied asynchronously and released by the system synchronously to clk; the block adds no reset synchronizer.

Configuration
REQ-026 Macro DEBOUNCE_RELEASE_PULSE_EN defined: D_release port and its per-channel falling-edge pulse logic exist per REQ-010/016.
REQ-027 Macro undefined: D_release port and its logic absent; D_level still follows 1->0 transitions normally.

Structure
REQ-028 Package debounce_pkg SHALL hold DEFAULT_NCH, DEFAULT_STABLE_CNT, MAX_STABLE_CNT, and a counter-width constant function.
REQ-029 Per-channel logic (synchronizer, counter, level, pulses) SHALL be sub-module debounce_chan, instantiated NCH times via generate.
REQ-030 Top level SHALL contain only parameter checks and the generate loop; no additional state.

Verification
REQ-031 NCH=4, STABLE_CNT=10, tick=1: D_in[0] steps 0->1 clean -> D_level[0]=1 and D_press[0] one cycle at edge 12 after capture; others stay 0.
REQ-032 Same config: D_in[1] high 9 ticks, low 1 tick, high 10 ticks -> exactly one D_press[1], timed from the final run start; no pulse from the 9-tick run.
REQ-033 tick pulsed every 4th clk, STABLE_CNT=3: clean step -> level change on the 3rd tick after sync (~12 clk); D_press width exactly 1 clk.
REQ-034 Channels 0 and 3 step high same cycle -> D_press=4'b1001 for one cycle; later both step low with macro defined -> D_release=4'b1001 one cycle, D_press=0.
REQ-035 Assert reset with counter at 7 of 10 and D_in high -> all outputs 0 immediately; after release, D_press fires once at 12 clk.
REQ-036 Build without DEBOUNCE_RELEASE_PULSE_EN: 1->0 step -> D_level falls at 12 clk, no D_release port exists, D_press stays 0.
